inc_arbiter: RTL and testbench
==============================

Name: inc_arbiter

Overview:
- Round-robin controller that shares one external combinational incrementer (d = a + 1) among NREQ requesters.
- Captures each requester's operand, drives the shared incrementer input from a register, and captures its output into a registered result tagged with the requester ID and an overflow flag.
- Sits between the datapath clients and the single INC instance in the datapath.

Parameters:
- DATAWIDTH, 16, operand/result width in bits (matches the shared incrementer width).
- NREQ, 4, number of requesters. Legal range 2..16. IDW = $clog2(NREQ).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- req  input  NREQ  level request, one bit per requester.
- a_bus  input  NREQ*DATAWIDTH  operands; requester i uses bits [i*DATAWIDTH +: DATAWIDTH].
- grant  output  NREQ  one-hot; high for exactly one cycle when an operand is accepted.
- busy  output  1  high while in EXEC.
- inc_a  output  DATAWIDTH  registered operand driven to the shared incrementer input.
- inc_d  input  DATAWIDTH  shared incrementer output; combinational from inc_a.
- d  output  DATAWIDTH  captured result.
- d_valid  output  1  one-cycle pulse; d, d_id and ovf are valid.
- d_id  output  IDW  index of the requester that owns d.
- ovf  output  1  high with d_valid when the operand was all ones, so d wrapped to 0.

Behaviour:
- Reset:
  - state = IDLE, ptr = 0.
  - grant = 0, busy = 0, inc_a = 0, d = 0, d_valid = 0, d_id = 0, ovf = 0.
- Reset asserted mid-operation aborts the in-flight op. No d_valid pulse is produced for it.
- FSM has two states, IDLE and EXEC.
- IDLE, when req != 0 at the edge:
  - Select winner w: the first set req bit searching from index ptr upward, wrapping at NREQ-1 to 0.
  - Register grant = onehot(w), inc_a = a_bus slice w, id_r = w, ovf_r = (slice == all ones).
  - Next state EXEC.
- IDLE, when req == 0: hold state; grant = 0.
- EXEC (exactly one cycle):
  - busy = 1, grant is high, inc_d settles from inc_a.
  - At the edge: d = inc_d, d_id = id_r, ovf = ovf_r, d_valid = 1, grant = 0, ptr = (w + 1) mod NREQ.
  - Next state IDLE.
  - req is ignored in EXEC.
- d_valid is cleared on the following edge unless a new capture occurs. d, d_id and ovf hold their values until the next capture.
- Latency and throughput:
  - req sampled at edge E → grant high during cycle E+1 → d_valid high during cycle E+2.
  - Maximum throughput is one operation per 2 cycles.
  - Back-to-back case: the IDLE cycle that shows d_valid may also issue the next grant.
- Requester protocol:
  - Hold req and operand stable until grant is seen.
  - Drop req in the cycle after grant.
  - req still high at the next IDLE sample counts as a new request.
- Arithmetic: the arbiter performs no addition. d is taken as inc_d, modulo 2^DATAWIDTH. ovf is computed from the captured operand, independent of inc_d.
- Simultaneous requests: only one winner per IDLE cycle. Losers keep req high and are served in rotating order. Starvation-free: any held req is granted within NREQ operations.
- inc_a holds its last value while idle.

Test Plan:
- Reset: assert Rst 2 cycles with req = 4'b1111 → all outputs 0, no grant, ptr = 0. After release, first grant = 4'b0001.
- Single request: req[2] = 1, a_bus slice 2 = 16'h00FF → grant = 4'b0100 at E+1, inc_a = 16'h00FF; at E+2, d = 16'h0100, d_id = 2, ovf = 0, d_valid pulse of 1 cycle.
- Wrap: req[1], operand 16'hFFFF → d = 16'h0000, ovf = 1, d_id = 1.
- Fairness: req = 4'b1111 held, each requester drops req after its grant → grant order 0, 1, 2, 3, one grant every 2 cycles. Then re-assert req[0] and req[3] → order 0, 3.
- Rotation from ptr: after serving 1 (ptr = 2), assert req = 4'b0011 → grant 0 before 1.
- Reset mid-op: assert Rst during EXEC → no d_valid, grant = 0 next cycle. The next request after release is served from ptr = 0.

Source files
------------

// File: rtl/inc_arbiter.sv
// inc_arbiter: round-robin sharing of one external combinational incrementer
// (inc_d = inc_a + 1) among NREQ requesters. The winning operand is parked
// in a register that drives the incrementer; one cycle later the incrementer
// output is captured together with the owner's index and an overflow flag.
//
// Handshake: a requester raises req[i] (level) with its operand stable on
// a_bus. In IDLE the arbiter samples req at the clock edge, picks one winner
// starting at the rotating pointer, and raises grant[i] for exactly one cycle
// (the EXEC cycle). The operand has been captured by then, so the requester
// drops req in the cycle after grant; a req still high at the next IDLE
// sample is a new request. The result appears as a one-cycle d_valid pulse
// one cycle after grant, carrying d, d_id and ovf, which then hold until the
// next capture.
module inc_arbiter #(
   parameter  int DATAWIDTH = 16,
   parameter  int NREQ      = 4,
   localparam int IDW       = $clog2(NREQ)
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*DATAWIDTH-1:0] a_bus,
   output logic [NREQ-1:0]           grant,
   output logic                      busy,
   output logic [DATAWIDTH-1:0]      inc_a,
   input  logic [DATAWIDTH-1:0]      inc_d,
   output logic [DATAWIDTH-1:0]      d,
   output logic                      d_valid,
   output logic [IDW-1:0]            d_id,
   output logic                      ovf,
   output logic                      o_dbg_state,
   output logic [IDW-1:0]            o_dbg_ptr
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_nxt_state;

   logic [IDW-1:0]         r_ptr;
   logic [NREQ-1:0]        r_grant;
   logic [DATAWIDTH-1:0]   r_inc_a;
   logic [IDW-1:0]         r_id;
   logic                   r_ovf_op;
   logic [DATAWIDTH-1:0]   r_d;
   logic                   r_d_valid;
   logic [IDW-1:0]         r_d_id;
   logic                   r_ovf;

   logic                   w_found;
   logic [IDW-1:0]         w_win;
   logic [DATAWIDTH-1:0]   w_oper;
   logic [NREQ-1:0]        w_onehot;
   logic                   w_accept;
   logic                   w_done;
   logic [IDW-1:0]         w_ptr_nxt;

   // Rotating priority search: first pass covers ptr..NREQ-1, second pass
   // picks up the wrap-around indices 0..ptr-1 (the only ones it can still find).
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_oper  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req[i] && (i >= int'(r_ptr))) begin
            w_found = 1'b1;
            w_win   = IDW'(i);
            w_oper  = a_bus[i*DATAWIDTH +: DATAWIDTH];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req[i]) begin
            w_found = 1'b1;
            w_win   = IDW'(i);
            w_oper  = a_bus[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   // Decode the winner index into the one-hot grant pattern.
   always_comb begin
      w_onehot        = '0;
      w_onehot[w_win] = 1'b1;
   end

   // Pointer moves to the requester just after the one being served.
   always_comb begin
      w_ptr_nxt = '0;
      if (r_id != IDW'(NREQ - 1)) begin
         w_ptr_nxt = r_id + 1'b1;
      end
   end

   // Next-state logic: accept in IDLE when anyone requests; EXEC lasts one cycle.
   always_comb begin
      w_nxt_state = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_accept    = 1'b1;
               w_nxt_state = EXEC;
            end
         end
         EXEC: begin
            w_done      = 1'b1;
            w_nxt_state = IDLE;
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Operand capture on accept, result capture on EXEC; reset aborts any op.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_ptr     <= '0;
         r_grant   <= '0;
         r_inc_a   <= '0;
         r_id      <= '0;
         r_ovf_op  <= 1'b0;
         r_d       <= '0;
         r_d_valid <= 1'b0;
         r_d_id    <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_d_valid <= 1'b0;
         if (w_accept) begin
            r_grant  <= w_onehot;
            r_inc_a  <= w_oper;
            r_id     <= w_win;
            r_ovf_op <= (w_oper == {DATAWIDTH{1'b1}});
         end else if (w_done) begin
            r_grant   <= '0;
            r_d       <= inc_d;
            r_d_id    <= r_id;
            r_ovf     <= r_ovf_op;
            r_d_valid <= 1'b1;
            r_ptr     <= w_ptr_nxt;
         end else begin
            r_grant <= '0;
         end
      end
   end

   assign grant       = r_grant;
   assign busy        = (r_state == EXEC);
   assign inc_a       = r_inc_a;
   assign d           = r_d;
   assign d_valid     = r_d_valid;
   assign d_id        = r_d_id;
   assign ovf         = r_ovf;
   assign o_dbg_state = r_state;
   assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_inc_arbiter.sv
// tb_inc_arbiter: directed bench for inc_arbiter with the shared incrementer
// modelled as a plain continuous assignment.
module tb_inc_arbiter;

  localparam int W    = 16;
  localparam int NREQ = 4;

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic [NREQ*W-1:0] a_bus;
  logic [NREQ-1:0]  grant;
  logic             busy;
  logic [W-1:0]     inc_a;
  logic [W-1:0]     inc_d;
  logic [W-1:0]     d;
  logic             d_valid;
  logic [1:0]       d_id;
  logic             ovf;
  logic             dbg_state;
  logic [1:0]       dbg_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  inc_arbiter #(.DATAWIDTH(W), .NREQ(NREQ)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .req        (req),
    .a_bus      (a_bus),
    .grant      (grant),
    .busy       (busy),
    .inc_a      (inc_a),
    .inc_d      (inc_d),
    .d          (d),
    .d_valid    (d_valid),
    .d_id       (d_id),
    .ovf        (ovf),
    .o_dbg_state(dbg_state),
    .o_dbg_ptr  (dbg_ptr)
  );

  // external shared incrementer
  assign inc_d = inc_a + 16'd1;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_bus;
    logic [NREQ-1:0]   exp_grant;
    logic [W-1:0]      exp_inc_a;
    logic [W-1:0]      exp_d;
    logic [1:0]        exp_id;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] fair_ops[4];
  int           order1[4];
  int           order2[2];

  initial begin
    // directed vectors; ptr entering each: 0,3,2,1,0,0
    vecs[0] = '{4'b0100, {16'hAAAA, 16'h00FF, 16'h5555, 16'h1111}, 4'b0100, 16'h00FF, 16'h0100, 2'd2, 1'b0};
    vecs[1] = '{4'b0010, {16'h0001, 16'h0002, 16'hFFFF, 16'h0003}, 4'b0010, 16'hFFFF, 16'h0000, 2'd1, 1'b1};
    vecs[2] = '{4'b0011, {16'hFFFF, 16'hFFFF, 16'h8888, 16'h1234}, 4'b0001, 16'h1234, 16'h1235, 2'd0, 1'b0};
    vecs[3] = '{4'b1001, {16'h7FFF, 16'h0000, 16'h0000, 16'hFFFF}, 4'b1000, 16'h7FFF, 16'h8000, 2'd3, 1'b0};
    vecs[4] = '{4'b1000, {16'hFFFE, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 16'hFFFE, 16'hFFFF, 2'd3, 1'b0};
    vecs[5] = '{4'b0110, {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}, 4'b0010, 16'h0000, 16'h0001, 2'd1, 1'b0};

    fair_ops = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    order1   = '{0, 1, 2, 3};
    order2   = '{0, 3};

    // reset with all requests pending
    rst   = 1'b1;
    req   = 4'b1111;
    a_bus = {fair_ops[3], fair_ops[2], fair_ops[1], fair_ops[0]};
    step();
    step();
    chk("rst_grant",   32'(grant),   32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_inc_a",   32'(inc_a),   32'h0);
    chk("rst_d",       32'(d),       32'h0);
    chk("rst_d_valid", 32'(d_valid), 32'h0);
    chk("rst_d_id",    32'(d_id),    32'h0);
    chk("rst_ovf",     32'(ovf),     32'h0);
    chk("rst_state",   32'(dbg_state), 32'h0);
    chk("rst_ptr",     32'(dbg_ptr), 32'h0);
    rst = 1'b0;

    // fairness: all four pending, each drops after its grant
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fair1_grant", 32'(grant), 32'(4'b0001 << order1[k]));
      chk("fair1_busy",  32'(busy),  32'h1);
      req[order1[k]] = 1'b0;
      step();
      chk("fair1_grant_off", 32'(grant),   32'h0);
      chk("fair1_dv",        32'(d_valid), 32'h1);
      chk("fair1_id",        32'(d_id),    32'(order1[k]));
      chk("fair1_d",         32'(d),       32'(W'(fair_ops[order1[k]] + 16'd1)));
    end

    // re-assert 0 and 3: ptr is back at 0
    req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("fair2_grant", 32'(grant), 32'(4'b0001 << order2[k]));
      req[order2[k]] = 1'b0;
      step();
      chk("fair2_dv", 32'(d_valid), 32'h1);
      chk("fair2_id", 32'(d_id),    32'(order2[k]));
    end
    step();
    chk("fair2_dv_off", 32'(d_valid), 32'h0);

    // table of single operations
    for (int v = 0; v < 6; v++) begin
      req   = vecs[v].req;
      a_bus = vecs[v].a_bus;
      step();
      chk("vec_grant", 32'(grant), 32'(vecs[v].exp_grant));
      chk("vec_busy",  32'(busy),  32'h1);
      chk("vec_inc_a", 32'(inc_a), 32'(vecs[v].exp_inc_a));
      req = '0;
      step();
      chk("vec_dv",        32'(d_valid), 32'h1);
      chk("vec_d",         32'(d),       32'(vecs[v].exp_d));
      chk("vec_id",        32'(d_id),    32'(vecs[v].exp_id));
      chk("vec_ovf",       32'(ovf),     32'(vecs[v].exp_ovf));
      chk("vec_grant_off", 32'(grant),   32'h0);
      chk("vec_busy_off",  32'(busy),    32'h0);
      step();
      chk("vec_dv_pulse", 32'(d_valid), 32'h0);
      chk("vec_d_hold",   32'(d),       32'(vecs[v].exp_d));
      chk("vec_ovf_hold", 32'(ovf),     32'(vecs[v].exp_ovf));
      chk("vec_inc_hold", 32'(inc_a),   32'(vecs[v].exp_inc_a));
    end
    chk("ptr_after_table", 32'(dbg_ptr), 32'h2);

    // back-to-back: req[0] held, one op every two cycles
    req   = 4'b0001;
    a_bus = {16'h0000, 16'h0000, 16'h0000, 16'h00AA};
    step();
    chk("b2b_g1",  32'(grant),   32'h1);
    chk("b2b_dv1", 32'(d_valid), 32'h0);
    step();
    chk("b2b_g2",  32'(grant),   32'h0);
    chk("b2b_dv2", 32'(d_valid), 32'h1);
    chk("b2b_d2",  32'(d),       32'h00AB);
    step();
    chk("b2b_g3",  32'(grant),   32'h1);
    chk("b2b_dv3", 32'(d_valid), 32'h0);
    req = '0;
    step();
    chk("b2b_dv4", 32'(d_valid), 32'h1);
    chk("b2b_g4",  32'(grant),   32'h0);

    // reset during EXEC: ptr is 1 here so req[2] wins
    req   = 4'b0100;
    a_bus = {16'h0000, 16'h0050, 16'h0000, 16'h0000};
    step();
    chk("mid_grant", 32'(grant), 32'h4);
    chk("mid_busy",  32'(busy),  32'h1);
    rst = 1'b1;
    req = '0;
    step();
    chk("mid_dv",    32'(d_valid), 32'h0);
    chk("mid_grant0", 32'(grant),  32'h0);
    chk("mid_busy0", 32'(busy),    32'h0);
    chk("mid_d",     32'(d),       32'h0);
    chk("mid_ptr",   32'(dbg_ptr), 32'h0);
    rst   = 1'b0;
    req   = 4'b1010;
    a_bus = {16'h0303, 16'h0000, 16'h0101, 16'h0000};
    step();
    chk("post_grant", 32'(grant), 32'h2);
    req = '0;
    step();
    chk("post_dv", 32'(d_valid), 32'h1);
    chk("post_id", 32'(d_id),    32'h1);
    chk("post_d",  32'(d),       32'h0102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish before %0t", $time);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
